// File: rtl/tq_premuat_pkg.sv
// Shared definitions for the even/odd lane permutation pipeline:
// size encodings, default sample width, handshake states and the
// lane-routing helper used to build the permutation network.
package tq_premuat_pkg;

    // Per-beat size encodings (number of points = 4 << code)
    localparam logic [1:0] SZ4  = 2'd0;
    localparam logic [1:0] SZ8  = 2'd1;
    localparam logic [1:0] SZ16 = 2'd2;
    localparam logic [1:0] SZ32 = 2'd3;

    // Default signed sample width
    localparam int DEFAULT_W = 19;

    // Handshake occupancy, encoded as {out_v, skid_v}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } premuat_state_e;

    // Effective point count: size code clamped to the lane count
    function automatic int premuat_eff_n(input int size, input int maxn);
        int n;
        n = 4 << size;
        return (n > maxn) ? maxn : n;
    endfunction

    // Source lane feeding output lane k for an n-point permutation.
    // Forward gathers evens into the low half and odds into the high half;
    // inverse interleaves the two halves back into natural order.
    function automatic int premuat_src(input int k, input int n, input logic inv);
        int half;
        half = n / 2;
        if (k >= n)
            return k;
        if (!inv)
            return (k < half) ? (2 * k) : (2 * (k - half) + 1);
        return ((k % 2) == 0) ? (k / 2) : (half + k / 2);
    endfunction

endpackage

// File: rtl/premuat_net.sv
// Combinational lane-routing network. Every output lane is a small mux
// over the eight (size, direction) modes; each mode's source lane is a
// constant resolved at elaboration, so only the select is run-time logic.
module premuat_net
    import tq_premuat_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int MAXN = 32
) (
    input  logic [MAXN*W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic              inverse_i,
    output logic [MAXN*W-1:0] data_o
);

    genvar gi, mi;

    generate
        for (gi = 0; gi < MAXN; gi++) begin : g_lane
            // Candidate samples for this lane, indexed by {size, inverse}
            logic [W-1:0] cand [8];

            for (mi = 0; mi < 8; mi++) begin : g_mode
                localparam int SRC = premuat_src(gi, premuat_eff_n(mi / 2, MAXN), 1'(mi % 2));
                assign cand[mi] = data_i[SRC*W +: W];
            end

            assign data_o[gi*W +: W] = cand[{size_i, inverse_i}];
        end
    endgenerate

endmodule

// File: rtl/premuat_pipe.sv
// Pipelined even/odd lane permutation with a valid/ready output stage.
// Incoming beats are permuted combinationally and then held in an output
// register backed by a one-entry skid register, so upstream readiness
// depends only on registered state and never on o_ready.
module premuat_pipe
    import tq_premuat_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int MAXN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [1:0]        i_size,
    input  logic              i_inverse,
    input  logic [MAXN*W-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [1:0]        o_size,
    output logic [MAXN*W-1:0] o_data
);

    premuat_state_e    state_q;
    logic [MAXN*W-1:0] out_data_q;
    logic [1:0]        out_size_q;
    logic [MAXN*W-1:0] skid_data_q;
    logic [1:0]        skid_size_q;
    logic [MAXN*W-1:0] net_data;
    logic              in_fire;
    logic              out_fire;

    // Permute ahead of storage so both OUT and SKID hold finished beats
    premuat_net #(
        .W    (W),
        .MAXN (MAXN)
    ) u_net (
        .data_i    (i_data),
        .size_i    (i_size),
        .inverse_i (i_inverse),
        .data_o    (net_data)
    );

    // Valid and ready come straight from the state register bits
    assign o_valid  = state_q[1];
    assign i_ready  = ~state_q[0];
    assign o_size   = out_size_q;
    assign o_data   = out_data_q;
    assign in_fire  = i_valid & i_ready;
    assign out_fire = o_valid & o_ready;

    // Occupancy FSM plus OUT/SKID data registers; SKID only ever refills OUT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_size_q  <= '0;
            skid_data_q <= '0;
            skid_size_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_data_q <= net_data;
                        out_size_q <= i_size;
                        state_q    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_data_q <= net_data;
                        out_size_q <= i_size;
                    end else if (in_fire) begin
                        skid_data_q <= net_data;
                        skid_size_q <= i_size;
                        state_q     <= ST_TWO;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        out_data_q <= skid_data_q;
                        out_size_q <= skid_size_q;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_premuat_pipe.sv
// Scoreboard bench for premuat_pipe: a 32-lane and an 8-lane instance share
// stimulus and o_ready; expected beats are queued on input transfer and
// compared, in order, on output transfer.
module tb_premuat_pipe;
    import tq_premuat_pkg::*;

    localparam int W     = 19;
    localparam int MAXN  = 32;
    localparam int MAXN8 = 8;

    typedef logic [MAXN*W-1:0] vec_t;
    typedef struct {
        vec_t       d32;
        vec_t       d8;
        logic [1:0] size;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic [1:0]        i_size;
    logic              i_inverse;
    vec_t              i_data;
    logic              o_ready;
    logic              i_ready, o_valid;
    logic [1:0]        o_size;
    vec_t              o_data;
    logic              i_ready8, o_valid8;
    logic [1:0]        o_size8;
    logic [MAXN8*W-1:0] o_data8;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    logic prev_stall = 1'b0;
    vec_t prev_data;
    logic [1:0] prev_size;

    premuat_pipe #(.W(W), .MAXN(MAXN)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_size(i_size), .i_inverse(i_inverse), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_size(o_size), .o_data(o_data)
    );

    premuat_pipe #(.W(W), .MAXN(MAXN8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready8),
        .i_size(i_size), .i_inverse(i_inverse), .i_data(i_data[MAXN8*W-1:0]),
        .o_valid(o_valid8), .o_ready(o_ready), .o_size(o_size8), .o_data(o_data8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference permutation written as the scatter form of the definition
    function automatic vec_t model(input vec_t din, input logic [1:0] size, input logic inv, input int maxn);
        vec_t r;
        int   n;
        n = 4 << size;
        if (n > maxn) n = maxn;
        r = din;
        for (int k = 0; k < n / 2; k++) begin
            if (!inv) begin
                r[k*W +: W]           = din[(2*k)*W +: W];
                r[(n/2 + k)*W +: W]   = din[(2*k + 1)*W +: W];
            end else begin
                r[(2*k)*W +: W]       = din[k*W +: W];
                r[(2*k + 1)*W +: W]   = din[(n/2 + k)*W +: W];
            end
        end
        return r;
    endfunction

    function automatic logic signed [W-1:0] lane(input vec_t v, input int k);
        return v[k*W +: W];
    endfunction

    function automatic vec_t ramp();
        vec_t v;
        for (int k = 0; k < MAXN; k++) v[k*W +: W] = W'(k);
        return v;
    endfunction

    // Observe one cycle just before the active edge
    task automatic sample();
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
            return;
        end
        check_eq("i_ready", i_ready, sb.size() < 2);
        check_eq("o_valid", o_valid, sb.size() != 0);
        check_eq("i_ready8", i_ready8, sb.size() < 2);
        check_eq("o_valid8", o_valid8, sb.size() != 0);
        if (prev_stall) begin
            check_eq("hold_data", o_data, prev_data);
            check_eq("hold_size", o_size, prev_size);
        end
        if (o_valid && o_ready && sb.size() > 0) begin
            e = sb.pop_front();
            n_popped++;
            check_eq("data32", o_data, e.d32);
            check_eq("size32", o_size, e.size);
            check_eq("data8", o_data8, e.d8[MAXN8*W-1:0]);
            check_eq("size8", o_size8, e.size);
        end
        if (i_valid && i_ready) begin
            e.d32  = model(i_data, i_size, i_inverse, MAXN);
            e.d8   = model(i_data, i_size, i_inverse, MAXN8);
            e.size = i_size;
            sb.push_back(e);
            n_pushed++;
        end
        prev_stall = o_valid && !o_ready;
        prev_data  = o_data;
        prev_size  = o_size;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic inv, input vec_t d);
        i_valid   = v;
        i_size    = s;
        i_inverse = inv;
        i_data    = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t r;
        int   exp8[8];
        int   exp4[4];
        int   base_push, base_pop, guard;

        exp8 = '{0, 2, 4, 6, 1, 3, 5, 7};
        exp4 = '{10, 30, -20, -40};
        r    = ramp();

        rst_n = 1'b0;
        o_ready = 1'b0;
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();
        cycle();
        rst_n = 1'b1;
        check_eq("rst_o_valid", o_valid, 1'b0);
        check_eq("rst_i_ready", i_ready, 1'b1);
        check_eq("rst_o_data", o_data, '0);
        check_eq("rst_o_size", o_size, 2'd0);
        check_eq("rst_o_data8", o_data8, '0);

        // N=4 forward on signed samples
        v = '0;
        v[0*W +: W] = W'(10);
        v[1*W +: W] = W'(-20);
        v[2*W +: W] = W'(30);
        v[3*W +: W] = W'(-40);
        o_ready = 1'b1;
        drive(1'b1, SZ4, 1'b0, v);
        cycle();
        check_eq("n4_valid", o_valid, 1'b1);
        for (int k = 0; k < 4; k++) check_eq($sformatf("n4_lane%0d", k), lane(o_data, k), W'(exp4[k]));
        check_eq("n4_size", o_size, 2'd0);
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();

        // N=8 forward on a ramp, upper lanes untouched
        drive(1'b1, SZ8, 1'b0, r);
        cycle();
        for (int k = 0; k < 8; k++) check_eq($sformatf("n8_lane%0d", k), lane(o_data, k), W'(exp8[k]));
        for (int k = 8; k < MAXN; k++) check_eq($sformatf("n8_pass%0d", k), lane(o_data, k), W'(k));
        check_eq("n8_size", o_size, 2'd1);
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();

        // N=32 forward then inverse back-to-back
        drive(1'b1, SZ32, 1'b0, r);
        cycle();
        check_eq("n32_fwd_l1", lane(o_data, 1), W'(2));
        check_eq("n32_fwd_l16", lane(o_data, 16), W'(1));
        check_eq("n8clamp_l1", o_data8[1*W +: W], W'(2));
        drive(1'b1, SZ32, 1'b1, model(r, SZ32, 1'b0, MAXN));
        check_eq("b2b_i_ready", i_ready, 1'b1);
        cycle();
        check_eq("b2b_valid", o_valid, 1'b1);
        check_eq("roundtrip", o_data, r);
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();

        // MAXN=8 instance with size 3 behaves as N=8
        drive(1'b1, SZ32, 1'b0, r);
        cycle();
        for (int k = 0; k < 8; k++) check_eq($sformatf("clamp_lane%0d", k), o_data8[k*W +: W], W'(exp8[k]));
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();

        // Random traffic with stalls on both sides
        base_push = n_pushed;
        base_pop  = n_popped;
        guard     = 0;
        while (((n_pushed - base_push) < 1000 || sb.size() > 0) && guard < 20000) begin
            for (int k = 0; k < MAXN; k++) v[k*W +: W] = W'($urandom);
            drive(((n_pushed - base_push) < 1000) && ($urandom_range(3) != 0),
                  2'($urandom_range(3)), 1'($urandom_range(1)), v);
            o_ready = ($urandom_range(9) < 6);
            cycle();
            guard++;
        end
        check_eq("rand_pushed", n_pushed - base_push, 1000);
        check_eq("rand_popped", n_popped - base_pop, 1000);
        check_eq("rand_drained", sb.size(), 0);

        // Fill to TWO, then reset mid-operation
        drive(1'b0, SZ4, 1'b0, '0);
        o_ready = 1'b1;
        cycle();
        o_ready = 1'b0;
        drive(1'b1, SZ16, 1'b0, r);
        cycle();
        drive(1'b1, SZ8, 1'b1, ~r);
        cycle();
        check_eq("two_i_ready", i_ready, 1'b0);
        check_eq("two_o_valid", o_valid, 1'b1);
        drive(1'b1, SZ4, 1'b0, r);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("mid_rst_o_valid", o_valid, 1'b0);
        check_eq("mid_rst_i_ready", i_ready, 1'b1);
        check_eq("mid_rst_o_data", o_data, '0);
        check_eq("mid_rst_o_size", o_size, 2'd0);
        for (int k = 0; k < MAXN; k++) v[k*W +: W] = W'(1000 + 3 * k);
        drive(1'b1, SZ16, 1'b1, v);
        o_ready = 1'b1;
        cycle();
        check_eq("post_rst_valid", o_valid, 1'b1);
        check_eq("post_rst_data", o_data, model(v, SZ16, 1'b1, MAXN));
        check_eq("post_rst_size", o_size, 2'd2);
        drive(1'b0, SZ4, 1'b0, '0);
        cycle();
        check_eq("post_rst_alone", o_valid, 1'b0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/premuat_pipe.md
# premuat_pipe

Parametrised, pipelined even/odd lane permutation for the transform/quantisation path. It accepts a vector of up to `MAXN` signed samples per beat. For a per-beat size of 4, 8, 16 or 32 points, it reorders the active lanes into even-index-first/odd-index-second order (forward) or restores natural order (inverse). The output is registered behind a valid/ready handshake with a one-entry skid buffer, so it can sit between butterfly stages that stall independently.

## Interface
- `W`, 19, sample width in bits (signed)
- `MAXN`, 32, lane count; legal values 4, 8, 16, 32
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `i_valid`  in  1  input beat valid
- `i_ready`  out  1  block can accept a beat this cycle
- `i_size`  in  2  points: 0=4, 1=8, 2=16, 3=32
- `i_inverse`  in  1  0=forward split, 1=inverse merge
- `i_data`  in  MAXN*W  lane k at bits [k*W +: W]
- `o_valid`  out  1  output beat valid
- `o_ready`  in  1  downstream accepts
- `o_size`  out  2  `i_size` of the beat being presented
- `o_data`  out  MAXN*W  permuted lanes

## Operation
- Effective size N = min(4<<i_size, MAXN). Lanes k >= N pass through unchanged.
- Forward, k < N/2: out[k] = in[2k] and out[N/2+k] = in[2k+1]. With N=4 this gives out = {in0, in2, in1, in3}.
- Inverse, k < N/2: out[2k] = in[k] and out[2k+1] = in[N/2+k]. Inverse(forward(x)) = x for every N.
- The permutation is pure lane routing; sample values and signs are never modified.
- Input transfer occurs when i_valid && i_ready. Output transfer occurs when o_valid && o_ready.
- Storage is an output register (OUT) plus one skid register (SKID). State is encoded as {out_v, skid_v}:
  - EMPTY {0,0}: input transfer -> ONE.
  - ONE {1,0}:
    - input transfer and output transfer -> ONE; OUT takes the new beat.
    - input transfer and no output transfer -> TWO; the new beat goes to SKID.
    - output transfer only -> EMPTY.
  - TWO {1,1}: i_ready = 0. Output transfer -> ONE; SKID moves to OUT.
- i_ready = !skid_v, driven from a register with no combinational path from o_ready.
- Beats leave in arrival order. o_size and the data lanes always belong to the same beat.

## Timing
- Reset (rst_n low at a clock edge):
  - out_v = 0, skid_v = 0, o_valid = 0, i_ready = 1.
  - o_data = 0, o_size = 0, SKID contents = 0.
- An input transfer in a cycle where rst_n is low is discarded.
- Reset mid-operation drops both held beats. The first beat after reset appears one cycle after its transfer.
- Latency: a beat accepted at edge t drives o_valid and o_data from edge t+1 when OUT was free or drained at t.
- Throughput: 1 beat/cycle while o_ready stays high.
- Backpressure: o_ready low for one cycle costs one bubble at most, and no data is lost. o_data is held stable while o_valid && !o_ready.
- i_size and i_inverse are sampled only on an input transfer. Changing them between beats is legal; each beat uses its own mode.
- i_size selecting N > MAXN is clamped to MAXN. This is not an error.

## Structure
- Package `tq_premuat_pkg` holds:
  - size encodings `SZ4`, `SZ8`, `SZ16`, `SZ32`;
  - default `W`;
  - function `premuat_src(k, n, inv)` returning the source lane index.
- Sub-module `premuat_net` is the combinational routing network, parametrised by `W` and `MAXN`, with inputs data, size and inverse. It is instantiated once in front of the OUT/SKID registers, so stored data is already permuted.
- The top level holds the handshake state, the registers and the skid mux.

## Test plan
- MAXN=4, forward, in lanes {10, -20, 30, -40}, o_ready=1 -> one cycle later o_data = {10, 30, -20, -40}, o_size=0.
- MAXN=32, i_size=1 (N=8), forward, lane k = k -> out {0,2,4,6,1,3,5,7}, lanes 8..31 = k unchanged.
- MAXN=32, N=32, back-to-back forward then inverse of the result, o_ready=1 -> second output equals the original ramp. Checks 1 beat/cycle.
- Random i_valid/o_ready stall pattern, 1000 beats, mixed sizes and modes:
  - output matches the reference model, in order, with no drops or duplicates;
  - i_ready is 0 exactly when TWO is held;
  - o_data is stable while stalled.
- Fill to TWO with o_ready=0, then pulse rst_n low for one cycle -> o_valid=0, i_ready=1, o_data=0; the next accepted beat emerges alone.
- MAXN=8 with i_size=3 -> behaves as N=8.
